// File: rtl/pacman_pkg.sv
// -----------------------------------------------------------------------------
// pacman_pkg
// Shared constants and types for the food-map logic.
//   ROWS / COLS  : food-map geometry (COLS is also the RAM word width)
//   *_W          : field widths for row/column addresses, counts and popcount
//   fm_state_e   : food-map arbiter FSM states
//   sat_add_count: food counter addition that sticks at all-ones
// -----------------------------------------------------------------------------
package pacman_pkg;

  localparam int ROWS  = 50;
  localparam int COLS  = 80;
  localparam int ROW_W = 6;
  localparam int COL_W = 7;
  localparam int CNT_W = 12;
  localparam int POP_W = 7;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    EAT_RD   = 3'd1,
    EAT_WAIT = 3'd2,
    EAT_WR   = 3'd3,
    REF_RD   = 3'd4,
    REF_WR   = 3'd5
  } fm_state_e;

  // Adds a row popcount to the pellet count; clamps instead of wrapping.
  function automatic logic [CNT_W-1:0] sat_add_count(
    input logic [CNT_W-1:0] cnt,
    input logic [POP_W-1:0] inc
  );
    logic [CNT_W:0] sum;
    sum = {1'b0, cnt} + {{(CNT_W + 1 - POP_W){1'b0}}, inc};
    if (sum[CNT_W]) begin
      return {CNT_W{1'b1}};
    end else begin
      return sum[CNT_W-1:0];
    end
  endfunction

endpackage

// File: rtl/popcount80.sv
// -----------------------------------------------------------------------------
// popcount80
// Combinational count of set bits in an 80-bit word.
//   data  : 80-bit input word
//   count : number of ones in data (0..80)
// -----------------------------------------------------------------------------
module popcount80
  import pacman_pkg::*;
(
  input  logic [79:0]      data,
  output logic [POP_W-1:0] count
);

  // Ripple sum of all bits; small enough to leave to synthesis.
  always_comb begin
    count = 7'd0;
    for (int i = 0; i < 80; i++) begin
      count = count + {6'd0, data[i]};
    end
  end

endmodule

// File: rtl/food_map_arbiter.sv
// -----------------------------------------------------------------------------
// food_map_arbiter
// Arbitrates a single-port food RAM between the display (absolute priority),
// pellet clearing ("eat") and start-of-level refill from a pattern ROM, and
// keeps a running count of pellets remaining.
//   clk, rst_n            : clock, asynchronous active-low reset
//   disp_req/disp_row_y   : display row read request; data returns next cycle
//   disp_row/disp_valid   : display read data (RAM read data) and its strobe
//   eat_req/eat_x/eat_y   : clear one pellet, request held until eat_ack
//   eat_ack/eat_hit       : completion pulse; hit = a pellet was removed
//   refill_req/_busy      : refill start pulse, refill in progress
//   pat_addr/pat_row      : pattern ROM address and data (1-cycle latency)
//   ram_*                 : food RAM port (1-cycle read latency)
//   food_count            : pellets remaining
// -----------------------------------------------------------------------------
module food_map_arbiter
  import pacman_pkg::*;
#(
  parameter int ROWS = pacman_pkg::ROWS,
  parameter int COLS = pacman_pkg::COLS
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             disp_req,
  input  logic [ROW_W-1:0] disp_row_y,
  output logic [COLS-1:0]  disp_row,
  output logic             disp_valid,
  input  logic             eat_req,
  input  logic [COL_W-1:0] eat_x,
  input  logic [ROW_W-1:0] eat_y,
  output logic             eat_ack,
  output logic             eat_hit,
  input  logic             refill_req,
  output logic             refill_busy,
  output logic [ROW_W-1:0] pat_addr,
  input  logic [COLS-1:0]  pat_row,
  output logic             ram_en,
  output logic             ram_we,
  output logic [ROW_W-1:0] ram_addr,
  output logic [COLS-1:0]  ram_wdata,
  input  logic [COLS-1:0]  ram_rdata,
  output logic [CNT_W-1:0] food_count
);

  localparam logic [COL_W-1:0] COL_LIM  = COL_W'(COLS);
  localparam logic [ROW_W-1:0] ROW_LIM  = ROW_W'(ROWS);
  localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);
  localparam logic [COLS-1:0]  BIT0     = {{(COLS - 1){1'b0}}, 1'b1};

  fm_state_e        state_r, state_nxt_s;
  logic [COL_W-1:0] x_r;
  logic [ROW_W-1:0] y_r;
  logic [ROW_W-1:0] row_r;
  logic [COLS-1:0]  hold_r;
  logic [COLS-1:0]  pat_hold_r;
  logic             pat_held_r;
  logic [CNT_W-1:0] food_count_r;
  logic             eat_ack_r, eat_hit_r, disp_valid_r, refill_busy_r;

  logic             ram_en_s, ram_we_s;
  logic [ROW_W-1:0] ram_addr_s;
  logic [COLS-1:0]  ram_wdata_s;
  logic             start_refill_s, accept_eat_s, reject_eat_s;
  logic             capture_hold_s, capture_pat_s, eat_wr_s, ref_wr_s;
  logic             eat_oob_s, hit_bit_s;
  logic [COLS-1:0]  eat_wdata_s, pat_wdata_s;
  logic [POP_W-1:0] pat_pop_s;

  assign eat_oob_s   = (eat_x >= COL_LIM) || (eat_y >= ROW_LIM);
  assign hit_bit_s   = hold_r[x_r];
  assign eat_wdata_s = hold_r & ~(BIT0 << x_r);
  // A stalled refill write uses the captured ROM row; otherwise ROM data is live.
  assign pat_wdata_s = pat_held_r ? pat_hold_r : pat_row;

  popcount80 u_popcount (
    .data  (pat_wdata_s),
    .count (pat_pop_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_nxt_s;
    end
  end

  // Next state, RAM port drive and datapath strobes; display always wins the port.
  always_comb begin
    state_nxt_s    = state_r;
    ram_en_s       = 1'b0;
    ram_we_s       = 1'b0;
    ram_addr_s     = {ROW_W{1'b0}};
    ram_wdata_s    = {COLS{1'b0}};
    start_refill_s = 1'b0;
    accept_eat_s   = 1'b0;
    reject_eat_s   = 1'b0;
    capture_hold_s = 1'b0;
    capture_pat_s  = 1'b0;
    eat_wr_s       = 1'b0;
    ref_wr_s       = 1'b0;

    if (disp_req) begin
      ram_en_s   = 1'b1;
      ram_addr_s = disp_row_y;
    end else begin
      ram_en_s   = 1'b0;
    end

    case (state_r)
      IDLE: begin
        if (refill_req) begin
          start_refill_s = 1'b1;
          state_nxt_s    = REF_RD;
        end else if (eat_req && !eat_ack_r) begin
          // eat_ack_r blocks re-acceptance of the request still held in the ack cycle.
          if (eat_oob_s) begin
            reject_eat_s = 1'b1;
          end else begin
            accept_eat_s = 1'b1;
            state_nxt_s  = EAT_RD;
          end
        end else begin
          state_nxt_s = IDLE;
        end
      end
      EAT_RD: begin
        if (!disp_req) begin
          ram_en_s    = 1'b1;
          ram_addr_s  = y_r;
          state_nxt_s = EAT_WAIT;
        end else begin
          state_nxt_s = EAT_RD;
        end
      end
      EAT_WAIT: begin
        // Read data lands now regardless of who owns the port this cycle.
        capture_hold_s = 1'b1;
        state_nxt_s    = EAT_WR;
      end
      EAT_WR: begin
        if (!disp_req) begin
          ram_en_s    = 1'b1;
          ram_we_s    = 1'b1;
          ram_addr_s  = y_r;
          ram_wdata_s = eat_wdata_s;
          eat_wr_s    = 1'b1;
          state_nxt_s = IDLE;
        end else begin
          state_nxt_s = EAT_WR;
        end
      end
      REF_RD: begin
        state_nxt_s = REF_WR;
      end
      REF_WR: begin
        if (!disp_req) begin
          ram_en_s    = 1'b1;
          ram_we_s    = 1'b1;
          ram_addr_s  = row_r;
          ram_wdata_s = pat_wdata_s;
          ref_wr_s    = 1'b1;
          state_nxt_s = (row_r == LAST_ROW) ? IDLE : REF_RD;
        end else begin
          capture_pat_s = !pat_held_r;
          state_nxt_s   = REF_WR;
        end
      end
      default: begin
        state_nxt_s = IDLE;
      end
    endcase

    if (!rst_n) begin
      ram_en_s    = 1'b0;
      ram_we_s    = 1'b0;
      ram_addr_s  = {ROW_W{1'b0}};
      ram_wdata_s = {COLS{1'b0}};
    end else begin
      ram_en_s    = ram_en_s;
    end
  end

  // Datapath registers: latched request, hold rows, counters and status outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_r           <= {COL_W{1'b0}};
      y_r           <= {ROW_W{1'b0}};
      row_r         <= {ROW_W{1'b0}};
      hold_r        <= {COLS{1'b0}};
      pat_hold_r    <= {COLS{1'b0}};
      pat_held_r    <= 1'b0;
      food_count_r  <= {CNT_W{1'b0}};
      eat_ack_r     <= 1'b0;
      eat_hit_r     <= 1'b0;
      disp_valid_r  <= 1'b0;
      refill_busy_r <= 1'b0;
    end else begin
      disp_valid_r <= disp_req;
      eat_ack_r    <= 1'b0;
      eat_hit_r    <= 1'b0;
      if (start_refill_s) begin
        row_r         <= {ROW_W{1'b0}};
        food_count_r  <= {CNT_W{1'b0}};
        refill_busy_r <= 1'b1;
        pat_held_r    <= 1'b0;
      end
      if (accept_eat_s) begin
        x_r <= eat_x;
        y_r <= eat_y;
      end
      if (reject_eat_s) begin
        eat_ack_r <= 1'b1;
      end
      if (capture_hold_s) begin
        hold_r <= ram_rdata;
      end
      if (capture_pat_s) begin
        pat_hold_r <= pat_row;
        pat_held_r <= 1'b1;
      end
      if (eat_wr_s) begin
        eat_ack_r <= 1'b1;
        eat_hit_r <= hit_bit_s;
        if (hit_bit_s && (food_count_r != {CNT_W{1'b0}})) begin
          food_count_r <= food_count_r - 12'd1;
        end
      end
      if (ref_wr_s) begin
        food_count_r <= sat_add_count(food_count_r, pat_pop_s);
        pat_held_r   <= 1'b0;
        if (row_r == LAST_ROW) begin
          refill_busy_r <= 1'b0;
        end else begin
          row_r <= row_r + 6'd1;
        end
      end
    end
  end

  assign disp_row    = ram_rdata;
  assign disp_valid  = disp_valid_r;
  assign eat_ack     = eat_ack_r;
  assign eat_hit     = eat_hit_r;
  assign refill_busy = refill_busy_r;
  assign pat_addr    = row_r;
  assign food_count  = food_count_r;
  assign ram_en      = ram_en_s;
  assign ram_we      = ram_we_s;
  assign ram_addr    = ram_addr_s;
  assign ram_wdata   = ram_wdata_s;

endmodule

// File: tb/tb_food_map_arbiter.sv
// -----------------------------------------------------------------------------
// tb_food_map_arbiter
// Scoreboard bench: each eat pushes its expected {eat_hit, food_count} into a
// queue; a negedge monitor pops on every eat_ack. The bench also models the
// food RAM and the pattern ROM (odd rows all ones, even rows all zeros).
// -----------------------------------------------------------------------------
module tb_food_map_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        disp_req = 1'b0;
  logic [5:0]  disp_row_y = 6'd0;
  logic [79:0] disp_row;
  logic        disp_valid;
  logic        eat_req = 1'b0;
  logic [6:0]  eat_x = 7'd0;
  logic [5:0]  eat_y = 6'd0;
  logic        eat_ack, eat_hit;
  logic        refill_req = 1'b0;
  logic        refill_busy;
  logic [5:0]  pat_addr;
  logic [79:0] pat_row = 80'd0;
  logic        ram_en, ram_we;
  logic [5:0]  ram_addr;
  logic [79:0] ram_wdata;
  logic [79:0] ram_rdata = 80'd0;
  logic [11:0] food_count;

  logic [79:0] mem [0:49];
  int          wr_cnt = 0;
  int          en_cnt = 0;
  int          n_tests = 0;
  int          n_fail = 0;
  logic [12:0] exp_q [$];
  logic        prev_disp = 1'b0;

  localparam logic [79:0] ONES   = {80{1'b1}};
  localparam logic [79:0] ROW3_A = ~(80'd1 << 5);
  localparam logic [79:0] ROW3_B = ~((80'd1 << 5) | (80'd1 << 7));

  food_map_arbiter dut (
    .clk(clk), .rst_n(rst_n),
    .disp_req(disp_req), .disp_row_y(disp_row_y), .disp_row(disp_row), .disp_valid(disp_valid),
    .eat_req(eat_req), .eat_x(eat_x), .eat_y(eat_y), .eat_ack(eat_ack), .eat_hit(eat_hit),
    .refill_req(refill_req), .refill_busy(refill_busy),
    .pat_addr(pat_addr), .pat_row(pat_row),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata), .food_count(food_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Food RAM model with one-cycle read latency.
  always @(posedge clk) begin
    if (ram_en) begin
      en_cnt    <= en_cnt + 1;
      ram_rdata <= mem[ram_addr];
      if (ram_we) begin
        mem[ram_addr] <= ram_wdata;
        wr_cnt        <= wr_cnt + 1;
      end
    end
  end

  // Pattern ROM model: odd rows full of pellets, even rows empty.
  always @(posedge clk) begin
    pat_row <= pat_addr[0] ? ONES : 80'd0;
  end

  // Monitor: display-priority and disp_valid checks, scoreboard pop on eat_ack.
  always @(negedge clk) begin
    if (rst_n) begin
      if (disp_req) begin
        check("disp_priority", {ram_en, ram_we, ram_addr}, {1'b1, 1'b0, disp_row_y});
      end
      check("disp_valid", disp_valid, prev_disp);
      if (eat_ack) begin
        if (exp_q.size() == 0) begin
          check("unexpected_eat_ack", 1'b1, 1'b0);
        end else begin
          check("eat_hit_count", {eat_hit, food_count}, exp_q.pop_front());
        end
      end
    end
    prev_disp <= disp_req;
  end

  // Waits for eat_ack, reports negedges elapsed (-1 on timeout), drops eat_req.
  task automatic wait_ack(output int lat);
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (eat_ack) begin
        lat = i;
        break;
      end
    end
    check("eat_ack_seen", (lat > 0), 1'b1);
    @(posedge clk); #1;
    eat_req = 1'b0;
  endtask

  task automatic do_eat(input logic [6:0] x, input logic [5:0] y,
                        input logic hit, input logic [11:0] cnt, output int lat);
    exp_q.push_back({hit, cnt});
    eat_x   = x;
    eat_y   = y;
    eat_req = 1'b1;
    wait_ack(lat);
  endtask

  initial begin
    int lat, busy_cycles, snap_wr, snap_en;
    logic busy_seen, busy_at_ack;
    for (int r = 0; r < 50; r++) mem[r] = 80'd0;

    // Reset state, with disp_req high to show the RAM port stays quiet.
    disp_req = 1'b1;
    repeat (2) @(posedge clk); #1;
    check("reset_outputs",
          {eat_ack, eat_hit, disp_valid, refill_busy, ram_en, ram_we, ram_addr, pat_addr, ram_wdata, food_count},
          128'd0);
    disp_req = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Full refill with a redundant refill_req in the middle.
    snap_wr = wr_cnt;
    refill_req = 1'b1;
    @(posedge clk); #1;
    refill_req = 1'b0;
    busy_cycles = 0;
    busy_seen = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (refill_busy) begin
        busy_cycles++;
        busy_seen = 1'b1;
      end else if (busy_seen) begin
        break;
      end
      if (i == 40) refill_req = 1'b1;
      if (i == 41) refill_req = 1'b0;
    end
    check("refill_busy_cycles", busy_cycles, 100);
    check("refill_writes", wr_cnt - snap_wr, 50);
    check("refill_count", food_count, 12'd2000);
    check("mem_row0", mem[0], 80'd0);
    check("mem_row3", mem[3], ONES);
    check("mem_row49", mem[49], ONES);

    // Eat a pellet, then the same spot again.
    do_eat(7'd5, 6'd3, 1'b1, 12'd1999, lat);
    check("row3_after_eat", mem[3], ROW3_A);
    do_eat(7'd5, 6'd3, 1'b0, 12'd1999, lat);
    check("row3_after_reeat", mem[3], ROW3_A);

    // Eat while the display owns the port for 20 cycles.
    @(posedge clk); #1;
    exp_q.push_back({1'b1, 12'd1998});
    snap_wr = wr_cnt;
    disp_req = 1'b1;
    disp_row_y = 6'd3;
    eat_x = 7'd7;
    eat_y = 6'd3;
    eat_req = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (i == 10) check("disp_row_during_stall", {disp_valid, disp_row}, {1'b1, ROW3_A});
    end
    check("no_write_while_disp", wr_cnt - snap_wr, 0);
    check("no_ack_while_disp", eat_ack, 1'b0);
    @(posedge clk); #1;
    disp_req = 1'b0;
    wait_ack(lat);
    check("stalled_eat_latency", lat, 4);
    check("row3_after_stalled_eat", mem[3], ROW3_B);

    // Out-of-range column and row: immediate miss, no RAM traffic.
    snap_en = en_cnt;
    do_eat(7'd80, 6'd0, 1'b0, 12'd1998, lat);
    check("oob_x_latency", lat, 2);
    do_eat(7'd0, 6'd50, 1'b0, 12'd1998, lat);
    check("oob_y_latency", lat, 2);
    check("oob_no_ram_en", en_cnt - snap_en, 0);

    // Refill and eat in the same cycle: refill first, then the eat.
    exp_q.push_back({1'b1, 12'd1999});
    eat_x = 7'd10;
    eat_y = 6'd1;
    eat_req = 1'b1;
    refill_req = 1'b1;
    @(posedge clk); #1;
    refill_req = 1'b0;
    busy_seen = 1'b0;
    busy_at_ack = 1'b1;
    lat = -1;
    for (int i = 1; i <= 300; i++) begin
      @(negedge clk);
      if (refill_busy) busy_seen = 1'b1;
      if (eat_ack) begin
        lat = i;
        busy_at_ack = refill_busy;
        break;
      end
    end
    check("combo_ack_seen", (lat > 0), 1'b1);
    check("combo_refill_first", {busy_seen, busy_at_ack}, {1'b1, 1'b0});
    @(posedge clk); #1;
    eat_req = 1'b0;
    check("row3_restored", mem[3], ONES);

    // Reset while the eat sits in EAT_WAIT.
    @(posedge clk); #1;
    eat_x = 7'd2;
    eat_y = 6'd5;
    eat_req = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    eat_req = 1'b0;
    #1;
    check("midop_reset_outputs",
          {eat_ack, eat_hit, disp_valid, refill_busy, ram_en, ram_we, ram_addr, pat_addr, ram_wdata, food_count},
          128'd0);
    repeat (2) @(posedge clk); #1;
    rst_n = 1'b1;
    snap_en = en_cnt;
    repeat (10) @(posedge clk); #1;
    check("post_reset_idle", {en_cnt - snap_en, eat_ack}, 0);
    check("row5_unwritten", mem[5], ONES);

    // Eat after reset: hit, but the count is already 0 and must stay there.
    do_eat(7'd2, 6'd5, 1'b1, 12'd0, lat);
    check("scoreboard_drained", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/food_map_arbiter.md
FOOD_MAP_ARBITER -- requirements
Module: food_map_arbiter

Interface
REQ-001 The block SHALL have parameter ROWS, default 50, meaning the number of food-map rows.
REQ-002 The block SHALL have parameter COLS, default 80, meaning the number of food-map columns (the RAM word width).
REQ-003 The block SHALL have one clock and an asynchronous, active-low reset, with these ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- disp_req  in  1  display read request (level)
- disp_row_y  in  6  row the display reads
- disp_row  out  80  read data, equal to ram_rdata
- disp_valid  out  1  disp_row valid
- eat_req  in  1  clear-one-pellet request (level, held until ack)
- eat_x  in  7  pellet column
- eat_y  in  6  pellet row
- eat_ack  out  1  one-cycle completion pulse
- eat_hit  out  1  qualifies eat_ack: a pellet was actually cleared
- refill_req  in  1  start-of-level refill pulse
- refill_busy  out  1  refill in progress
- pat_addr  out  6  initial-pattern ROM row address
- pat_row  in  80  pattern ROM data, one-cycle latency
- ram_en, ram_we  out  1 each  food RAM port controls
- ram_addr  out  6  food RAM row address
- ram_wdata  out  80  food RAM write data
- ram_rdata  in  80  food RAM read data, one-cycle latency
- food_count  out  12  pellets remaining

Function
REQ-004 The display SHALL have absolute priority: whenever disp_req=1, the block SHALL drive ram_en=1, ram_we=0 and ram_addr=disp_row_y in that cycle.
REQ-005 disp_valid SHALL be disp_req delayed by one cycle.
REQ-006 Eat and refill RAM accesses SHALL occur only in cycles with disp_req=0.
REQ-007 The FSM SHALL have states IDLE, EAT_RD, EAT_WAIT, EAT_WR, REF_RD, REF_WR.
REQ-008 If refill_req=1 in IDLE, the FSM SHALL go to REF_RD with row counter 0; refill SHALL win over a simultaneous eat_req.
REQ-009 Otherwise, if eat_req=1 in IDLE, the block SHALL latch eat_x/eat_y and go to EAT_RD.
REQ-010 If eat_x>=COLS or eat_y>=ROWS, the block SHALL instead pulse eat_ack with eat_hit=0 and perform no RAM access.
REQ-011 EAT_RD SHALL issue a read of the latched row on the first free cycle, then move to EAT_WAIT.
REQ-012 EAT_WAIT SHALL capture ram_rdata into a holding register on the next cycle, independent of disp_req.
REQ-013 EAT_WR SHALL write the held row with bit eat_x cleared on the first free cycle, then return to IDLE.
REQ-014 With the EAT_WR write, the block SHALL pulse eat_ack and set eat_hit to the bit's prior value.
REQ-015 food_count SHALL decrement by 1 only when eat_hit=1.
REQ-016 A held read or write SHALL stall without losing data while disp_req=1.
REQ-017 REF_RD SHALL drive pat_addr=row; REF_WR SHALL write pat_row to ram_addr=row on the next free cycle.
REQ-018 If a REF_WR write stalls, pat_row SHALL be captured the cycle after pat_addr and held until the write.
REQ-019 Each REF_WR write SHALL add popcount(pat_row) to food_count, which is cleared to 0 on refill entry.
REQ-020 After row ROWS-1 is written, refill SHALL return to IDLE.
REQ-021 refill_busy SHALL be 1 from REF_RD entry to the last write inclusive.
REQ-022 refill_req while refill_busy=1 SHALL be ignored.
REQ-023 eat_req during a refill SHALL be served after the refill completes.
REQ-024 food_count SHALL saturate at 0 and never wrap.

Reset
REQ-025 On rst_n=0, asynchronously: state IDLE; food_count 0; eat_ack, eat_hit, disp_valid, refill_busy, ram_en, ram_we all 0; ram_addr, pat_addr, ram_wdata 0.
REQ-026 Reset mid-operation SHALL abort the operation; RAM contents are not restored.
REQ-027 eat_ack SHALL not pulse for an eat aborted by reset.

Structure
REQ-028 ROWS, COLS and the FSM state enumeration SHALL live in shared package pacman_pkg.
REQ-029 Popcount SHALL be a separate sub-module, popcount80 (80-bit in, 7-bit out, combinational).

Verification
REQ-030 Refill with pattern rows alternating all-ones/all-zeros, disp_req=0 -> refill_busy for 100 cycles, 50 writes, food_count=2000.
REQ-031 Eat (x=5,y=3) after refill -> ram row 3 bit 5 becomes 0, eat_hit=1, food_count=1999; repeat same eat -> eat_hit=0, count unchanged.
REQ-032 eat_req with disp_req=1 for 20 cycles -> no RAM write until disp_req=0; display reads uncorrupted; eat completes 3 free cycles later.
REQ-033 eat_x=80 -> eat_ack next cycle, eat_hit=0, ram_en never asserted for it.
REQ-034 refill_req and eat_req in same cycle -> refill completes first, then eat acked.
REQ-035 rst_n low during EAT_WAIT -> all outputs 0 immediately, no eat_ack, FSM IDLE after release.
